// File: rtl/sram_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_arb_pkg
// Purpose  : Shared types and default widths for the SRAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;
  localparam int c_ADDR_W        = 20;
  localparam int c_DATA_W        = 16;
  localparam int c_ACCESS_CYCLES = 2;
  localparam int c_HOST_MAX_WAIT = 8;
  localparam int c_CNT_W         = 4;
  localparam int c_WAIT_W        = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    TURN   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REQ_DISP = 2'd0,
    REQ_VID  = 2'd1,
    REQ_HOST = 2'd2
  } req_id_e;
endpackage
`default_nettype wire

// File: rtl/sram_arb_prio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_arb_prio
// Purpose  : Combinational winner select: starved host first, else disp > vid > host.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arb_prio
  import sram_arb_pkg::*;
#(
  parameter int HOST_MAX_WAIT = c_HOST_MAX_WAIT
) (
  input  logic                i_disp_req,
  input  logic                i_vid_req,
  input  logic                i_host_req,
  input  logic [c_WAIT_W-1:0] i_host_wait,
  output logic                o_any,
  output req_id_e             o_win
);
  always_comb begin
    o_any = i_disp_req | i_vid_req | i_host_req;
    o_win = REQ_HOST;
    if (i_host_req && (i_host_wait == c_WAIT_W'(HOST_MAX_WAIT))) begin
      o_win = REQ_HOST;
    end else if (i_disp_req) begin
      o_win = REQ_DISP;
    end else if (i_vid_req) begin
      o_win = REQ_VID;
    end
  end
endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Three-way arbiter and strobe sequencer for the async 16-bit SRAM.
//            Optional grant counters enabled by defining SRAM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = c_ADDR_W,
  parameter int DATA_W        = c_DATA_W,
  parameter int ACCESS_CYCLES = c_ACCESS_CYCLES,
  parameter int HOST_MAX_WAIT = c_HOST_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [DATA_W-1:0] vid_wdata,
  input  logic [1:0]        vid_be,
  output logic              vid_ack,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [1:0]        host_be,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
`ifdef SRAM_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_disp,
  output logic [15:0]       stat_vid,
  output logic [15:0]       stat_host
`endif
);
  state_e              r_state, w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  req_id_e             r_id, w_id_nxt;
  logic                r_we, w_we_nxt;
  logic [1:0]          r_be, w_be_nxt;
  logic [c_WAIT_W-1:0] r_host_wait, w_host_wait_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_dq_o, w_dq_o_nxt;
  logic                r_dq_oe, w_dq_oe_nxt;
  logic                r_ce_n, r_oe_n, r_we_n, r_lb_n, r_ub_n;
  logic                w_ce_n, w_oe_n, w_we_n, w_lb_n, w_ub_n;
  logic                r_disp_ack, r_vid_ack, r_host_ack;
  logic                w_disp_ack, w_vid_ack, w_host_ack;
  logic [DATA_W-1:0]   r_disp_rdata, r_host_rdata, w_disp_rdata, w_host_rdata;
  logic                w_any;
  req_id_e             w_win;

  sram_arb_prio #(.HOST_MAX_WAIT(HOST_MAX_WAIT)) u_prio (
    .i_disp_req  (disp_req),
    .i_vid_req   (vid_req),
    .i_host_req  (host_req),
    .i_host_wait (r_host_wait),
    .o_any       (w_any),
    .o_win       (w_win)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_id_nxt     = r_id;
    w_we_nxt     = r_we;
    w_be_nxt     = r_be;
    w_addr_nxt   = r_addr;
    w_dq_o_nxt   = r_dq_o;
    w_dq_oe_nxt  = 1'b0;
    w_ce_n       = 1'b1;
    w_oe_n       = 1'b1;
    w_we_n       = 1'b1;
    w_lb_n       = 1'b1;
    w_ub_n       = 1'b1;
    w_disp_ack   = 1'b0;
    w_vid_ack    = 1'b0;
    w_host_ack   = 1'b0;
    w_disp_rdata = r_disp_rdata;
    w_host_rdata = r_host_rdata;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_id_nxt = w_win;
          unique case (w_win)
            REQ_DISP: begin
              w_addr_nxt = disp_addr;
              w_we_nxt   = 1'b0;
              w_be_nxt   = 2'b11;
            end
            REQ_VID: begin
              w_addr_nxt = vid_addr;
              w_dq_o_nxt = vid_wdata;
              w_we_nxt   = 1'b1;
              w_be_nxt   = vid_be;
            end
            default: begin
              w_addr_nxt = host_addr;
              w_dq_o_nxt = host_wdata;
              w_we_nxt   = host_we;
              w_be_nxt   = host_we ? host_be : 2'b11;
            end
          endcase
          w_ce_n      = 1'b0;
          w_oe_n      = w_we_nxt;
          w_we_n      = ~w_we_nxt;
          w_lb_n      = ~w_be_nxt[0];
          w_ub_n      = ~w_be_nxt[1];
          w_dq_oe_nxt = w_we_nxt;
          w_cnt_nxt   = c_CNT_W'(ACCESS_CYCLES - 1);
          w_state_nxt = STROBE;
        end
      end
      STROBE: begin
        // Write data keeps driving through TURN for SRAM hold time.
        w_dq_oe_nxt = r_we;
        if (r_cnt == '0) begin
          w_state_nxt = TURN;
          w_disp_ack  = (r_id == REQ_DISP);
          w_vid_ack   = (r_id == REQ_VID);
          w_host_ack  = (r_id == REQ_HOST);
          if (!r_we && r_id == REQ_DISP) w_disp_rdata = sram_dq_i;
          if (!r_we && r_id == REQ_HOST) w_host_rdata = sram_dq_i;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          w_ce_n    = 1'b0;
          w_oe_n    = r_we;
          w_we_n    = ~r_we;
          w_lb_n    = ~r_be[0];
          w_ub_n    = ~r_be[1];
        end
      end
      TURN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_host_wait_nxt = r_host_wait;
    if (!host_req) begin
      w_host_wait_nxt = '0;
    end else if (r_state == IDLE && w_any) begin
      if (w_win == REQ_HOST) begin
        w_host_wait_nxt = '0;
      end else if (r_host_wait != c_WAIT_W'(HOST_MAX_WAIT)) begin
        w_host_wait_nxt = r_host_wait + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_id         <= REQ_DISP;
      r_we         <= 1'b0;
      r_be         <= 2'b11;
      r_host_wait  <= '0;
      r_addr       <= '0;
      r_dq_o       <= '0;
      r_dq_oe      <= 1'b0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_lb_n       <= 1'b1;
      r_ub_n       <= 1'b1;
      r_disp_ack   <= 1'b0;
      r_vid_ack    <= 1'b0;
      r_host_ack   <= 1'b0;
      r_disp_rdata <= '0;
      r_host_rdata <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_id         <= w_id_nxt;
      r_we         <= w_we_nxt;
      r_be         <= w_be_nxt;
      r_host_wait  <= w_host_wait_nxt;
      r_addr       <= w_addr_nxt;
      r_dq_o       <= w_dq_o_nxt;
      r_dq_oe      <= w_dq_oe_nxt;
      r_ce_n       <= w_ce_n;
      r_oe_n       <= w_oe_n;
      r_we_n       <= w_we_n;
      r_lb_n       <= w_lb_n;
      r_ub_n       <= w_ub_n;
      r_disp_ack   <= w_disp_ack;
      r_vid_ack    <= w_vid_ack;
      r_host_ack   <= w_host_ack;
      r_disp_rdata <= w_disp_rdata;
      r_host_rdata <= w_host_rdata;
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] r_stat_disp, r_stat_vid, r_stat_host;

  // Counters follow the registered acks; clear has priority over a same-cycle ack.
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      r_stat_disp <= '0;
      r_stat_vid  <= '0;
      r_stat_host <= '0;
    end else begin
      if (r_disp_ack && r_stat_disp != 16'hFFFF) r_stat_disp <= r_stat_disp + 1'b1;
      if (r_vid_ack  && r_stat_vid  != 16'hFFFF) r_stat_vid  <= r_stat_vid  + 1'b1;
      if (r_host_ack && r_stat_host != 16'hFFFF) r_stat_host <= r_stat_host + 1'b1;
    end
  end

  assign stat_disp = r_stat_disp;
  assign stat_vid  = r_stat_vid;
  assign stat_host = r_stat_host;
`endif

  assign sram_addr  = r_addr;
  assign sram_dq_o  = r_dq_o;
  assign sram_dq_oe = r_dq_oe;
  assign sram_ce_n  = r_ce_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;
  assign sram_lb_n  = r_lb_n;
  assign sram_ub_n  = r_ub_n;
  assign disp_ack   = r_disp_ack;
  assign vid_ack    = r_vid_ack;
  assign host_ack   = r_host_ack;
  assign disp_rdata = r_disp_rdata;
  assign host_rdata = r_host_rdata;
endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Scoreboard bench for sram_port_arbiter with a byte-lane SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  typedef struct {
    int          id;
    int          cyc;
    logic        chk_data;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_req, vid_req, host_req, host_we;
  logic [19:0] disp_addr, vid_addr, host_addr, sram_addr;
  logic [15:0] vid_wdata, host_wdata, disp_rdata, host_rdata, sram_dq_o, sram_dq_i;
  logic [1:0]  vid_be, host_be;
  logic        disp_ack, vid_ack, host_ack, sram_dq_oe;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
`ifdef SRAM_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_disp, stat_vid, stat_host;
`endif

  logic [15:0] mem [256];
  exp_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_acks = 0;

  sram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack), .disp_rdata(disp_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_wdata(vid_wdata), .vid_be(vid_be), .vid_ack(vid_ack),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_be(host_be), .host_ack(host_ack), .host_rdata(host_rdata),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
`ifdef SRAM_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_disp(stat_disp), .stat_vid(stat_vid), .stat_host(stat_host)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM model: lanes written while CE_N and WE_N are low.
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq_o[7:0];
      if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq_o[15:8];
    end
  end
  assign sram_dq_i = mem[sram_addr[7:0]];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input int id, input int c, input logic cd, input logic [15:0] d);
    exp_t e;
    e.id = id; e.cyc = c; e.chk_data = cd; e.data = d;
    sb.push_back(e);
  endtask

  task automatic mon_step();
    exp_t e;
    int   gid;
    if (disp_ack || vid_ack || host_ack) begin
      n_acks++;
      chk("ack_onehot", 32'($countones({disp_ack, vid_ack, host_ack})), 1);
      gid = disp_ack ? 0 : (vid_ack ? 1 : 2);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(gid), 32'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("ack_id", 32'(gid), 32'(e.id));
        if (e.cyc >= 0) chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chk_data) chk("rdata", {16'h0, (gid == 0) ? disp_rdata : host_rdata}, {16'h0, e.data});
      end
    end
  endtask

  task automatic disp_rd(input logic [19:0] a);
    disp_req = 1'b1; disp_addr = a;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (disp_ack) break;
    end
    if (!disp_ack) chk("disp_timeout", 0, 1);
    disp_req = 1'b0;
  endtask

  task automatic vid_wr(input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
    vid_req = 1'b1; vid_addr = a; vid_wdata = d; vid_be = be;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (vid_ack) break;
    end
    if (!vid_ack) chk("vid_timeout", 0, 1);
    vid_req = 1'b0;
  endtask

  task automatic host_acc(input logic we, input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; host_be = be;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (host_ack) break;
    end
    if (!host_ack) chk("host_timeout", 0, 1);
    host_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n_we, n_oe, n_lane, base;
    reset = 1'b1;
    disp_req = 0; vid_req = 0; host_req = 0; host_we = 0;
    disp_addr = 0; vid_addr = 0; host_addr = 0;
    vid_wdata = 0; host_wdata = 0; vid_be = 0; host_be = 0;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_ce_n", sram_ce_n, 1);  chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_we_n", sram_we_n, 1);  chk("rst_lb_n", sram_lb_n, 1);
    chk("rst_ub_n", sram_ub_n, 1);  chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_addr", sram_addr, 0);  chk("rst_dq_o", sram_dq_o, 0);
    chk("rst_acks", {disp_ack, vid_ack, host_ack}, 0);
    chk("rst_rdata", {disp_rdata, host_rdata}, 0);
    reset = 1'b0;

    // Host write then read-back, with strobe shape and latency.
    @(negedge clk);
    c = cyc; n_we = 0; n_oe = 0;
    push(int'(REQ_HOST), c + 3, 1'b0, 16'h0);
    fork
      host_acc(1'b1, 20'h12345, 16'hBEEF, 2'b11);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (!sram_we_n) begin
          n_we++;
          chk("wr_addr", sram_addr, 20'h12345);
          chk("wr_data", sram_dq_o, 16'hBEEF);
        end
        if (sram_dq_oe) n_oe++;
      end
    join
    chk("wr_we_cycles", n_we, 2);
    chk("wr_oe_cycles", n_oe, 3);
    @(negedge clk);
    push(int'(REQ_HOST), cyc + 3, 1'b1, 16'hBEEF);
    host_acc(1'b0, 20'h12345, 16'h0, 2'b00);

    // Simultaneous requests: disp, vid, host in that order.
    @(negedge clk);
    c = cyc;
    push(int'(REQ_DISP), c + 3,  1'b1, 16'hBEEF);
    push(int'(REQ_VID),  c + 7,  1'b0, 16'h0);
    push(int'(REQ_HOST), c + 11, 1'b1, 16'hA5C3);
    fork
      disp_rd(20'h12345);
      vid_wr(20'h00077, 16'hA5C3, 2'b11);
      host_acc(1'b0, 20'h00077, 16'h0, 2'b00);
    join

    // Upper-byte-only video write, then readback merges lanes.
    @(negedge clk);
    n_lane = 0;
    push(int'(REQ_VID), cyc + 3, 1'b0, 16'h0);
    fork
      vid_wr(20'h12345, 16'h12AB, 2'b10);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (!sram_ce_n) begin
          n_lane++;
          chk("be_ub_n", sram_ub_n, 0);
          chk("be_lb_n", sram_lb_n, 1);
        end
      end
    join
    chk("be_strobe_cycles", n_lane, 2);
    @(negedge clk);
    push(int'(REQ_DISP), cyc + 3, 1'b1, 16'h12EF);
    disp_rd(20'h12345);

    // Host starvation: eight disp grants, then host, then counter restarts.
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) push(int'(REQ_DISP), -1, 1'b0, 16'h0);
      push(int'(REQ_HOST), -1, 1'b0, 16'h0);
    end
    base = n_acks;
    disp_req = 1; disp_addr = 20'h00011;
    vid_req = 1; vid_addr = 20'h00022; vid_wdata = 16'h1111; vid_be = 2'b11;
    host_req = 1; host_we = 0; host_addr = 20'h00033;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (n_acks - base >= 18) break;
    end
    disp_req = 0; vid_req = 0; host_req = 0;
    chk("starve_acks", 32'(n_acks - base), 18);
    chk("starve_sb_drained", 32'(sb.size()), 0);
    repeat (3) @(negedge clk);

    // Reset during the second strobe cycle of a write.
    c = cyc;
    host_req = 1; host_we = 1; host_addr = 20'h00099; host_wdata = 16'h1234; host_be = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("abort_mid_we_n", sram_we_n, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ce_n", sram_ce_n, 1);  chk("abort_we_n", sram_we_n, 1);
    chk("abort_oe_n", sram_oe_n, 1);  chk("abort_lanes", {sram_lb_n, sram_ub_n}, 2'b11);
    chk("abort_dq_oe", sram_dq_oe, 0);
    chk("abort_ack", {disp_ack, vid_ack, host_ack}, 0);
    reset = 1'b0; host_req = 0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_ack", {disp_ack, vid_ack, host_ack}, 0);
    end
    push(int'(REQ_HOST), cyc + 3, 1'b0, 16'h0);
    host_acc(1'b1, 20'h00099, 16'h5678, 2'b11);
    @(negedge clk);
    push(int'(REQ_HOST), cyc + 3, 1'b1, 16'h5678);
    host_acc(1'b0, 20'h00099, 16'h0, 2'b00);

`ifdef SRAM_ARB_STATS_EN
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    chk("stat_clr_disp", stat_disp, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      push(int'(REQ_DISP), -1, 1'b0, 16'h0);
      disp_rd(20'h12345);
    end
    @(negedge clk);
    chk("stat_disp_3", stat_disp, 3);
    push(int'(REQ_DISP), -1, 1'b0, 16'h0);
    disp_rd(20'h12345);
    chk("stat_disp_pre_clr", stat_disp, 3);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    chk("stat_disp_clr", stat_disp, 0);
    chk("stat_vid_host", {stat_vid, stat_host}, 0);
`endif

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
